// File: rtl/computer_player.sv
// Computer opponent for the tug-of-war game: presses its button on random decision ticks.
// Optional streak limiter enabled by defining CPU_STREAK_LIMIT_EN.
module computer_player #(
  parameter int TICK_DIV = 1024,
  parameter int COOLDOWN = 4,
  parameter int LFSR_W   = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LFSR_W-1:0] lfsr_q,
  input  logic [LFSR_W-1:0] difficulty,
  input  logic              game_on,
  output logic              press_out,
  output logic              busy
);

  // state    | meaning
  // IDLE     | waiting for a tick to decide whether to press
  // PRESS    | one-cycle button press
  // COOLDOWN | skipping decision ticks after a press
  typedef enum logic [1:0] {IDLE, PRESS, COOLDOWN_ST} state_t;

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0] CD_LOAD = 8'(COOLDOWN);

  state_t        state;
  logic [PW-1:0] prescale;
  logic [7:0]    cd_cnt;
  logic          tick;
  logic          want_press;
  logic          do_press;

  assign tick       = game_on && (prescale == PS_LAST);
  assign want_press = lfsr_q < difficulty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      prescale <= '0;
    else if (!game_on || tick)
      prescale <= '0;
    else
      prescale <= prescale + 1'b1;
  end

`ifdef CPU_STREAK_LIMIT_EN
  logic [1:0] streak;

  // After three presses in a row, the next eligible tick is forced to pass.
  assign do_press = want_press && (streak != 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      streak <= '0;
    else if (game_on && tick && state == IDLE) begin
      if (do_press)
        streak <= streak + 1'b1;
      else
        streak <= '0;
    end
  end
`else
  assign do_press = want_press;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cd_cnt    <= '0;
      press_out <= 1'b0;
      busy      <= 1'b0;
    end else if (!game_on) begin
      state     <= IDLE;
      cd_cnt    <= '0;
      press_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          press_out <= 1'b0;
          busy      <= 1'b0;
          if (tick && do_press) begin
            state     <= PRESS;
            press_out <= 1'b1;
            busy      <= 1'b1;
          end
        end
        PRESS: begin
          state     <= COOLDOWN_ST;
          cd_cnt    <= CD_LOAD;
          press_out <= 1'b0;
          busy      <= 1'b1;
        end
        COOLDOWN_ST: begin
          press_out <= 1'b0;
          // The tick that reaches the terminal count only releases to IDLE.
          if (tick) begin
            if (cd_cnt <= 8'd1) begin
              state  <= IDLE;
              cd_cnt <= '0;
              busy   <= 1'b0;
            end else begin
              cd_cnt <= cd_cnt - 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          cd_cnt    <= '0;
          press_out <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_computer_player.sv
// Self-checking bench for computer_player with TICK_DIV=4, COOLDOWN=2.
module tb_computer_player;

  logic       clk = 1'b0;
  logic       reset;
  logic       game_on;
  logic [8:0] lfsr_q;
  logic [8:0] difficulty;
  logic       press_out;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {int cyc; logic press; logic busy;} exp_t;
  typedef struct {logic [8:0] diff; logic [8:0] lfsr; logic press;} vec_t;

  exp_t sb[$];
  vec_t vecs[11];

  computer_player #(.TICK_DIV(4), .COOLDOWN(2), .LFSR_W(9)) dut (
    .clk       (clk),
    .reset     (reset),
    .lfsr_q    (lfsr_q),
    .difficulty(difficulty),
    .game_on   (game_on),
    .press_out (press_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp, input int cyc);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Leaves the DUT idle with the prescaler cleared, positioned at a falling edge.
  task automatic idle_round();
    game_on = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  // Cycle k is the cycle after rising edge k counted from when game_on went high.
  // A press at cycle p keeps busy high through cycle p+7 (two cooldown ticks of 4 clk).
  task automatic run_seq(input string name, input int first, input int last, input int presses[$]);
    exp_t e;
    for (int k = first; k <= last; k++) begin
      e.cyc = k; e.press = 1'b0; e.busy = 1'b0;
      foreach (presses[i]) begin
        if (k == presses[i]) e.press = 1'b1;
        if (k >= presses[i] && k <= presses[i] + 7) e.busy = 1'b1;
      end
      sb.push_back(e);
    end
    while (sb.size() > 0) begin
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      check({name, " press_out"}, press_out, e.press, e.cyc);
      check({name, " busy"}, busy, e.busy, e.cyc);
    end
  endtask

  initial begin
    int pq[$];

    vecs[0]  = '{diff: 9'd0,   lfsr: 9'd0,   press: 1'b0};
    vecs[1]  = '{diff: 9'd0,   lfsr: 9'd5,   press: 1'b0};
    vecs[2]  = '{diff: 9'd100, lfsr: 9'd100, press: 1'b0};
    vecs[3]  = '{diff: 9'd100, lfsr: 9'd99,  press: 1'b1};
    vecs[4]  = '{diff: 9'd100, lfsr: 9'd101, press: 1'b0};
    vecs[5]  = '{diff: 9'd511, lfsr: 9'd5,   press: 1'b1};
    vecs[6]  = '{diff: 9'd511, lfsr: 9'd511, press: 1'b0};
    vecs[7]  = '{diff: 9'd511, lfsr: 9'd510, press: 1'b1};
    vecs[8]  = '{diff: 9'd1,   lfsr: 9'd0,   press: 1'b1};
    vecs[9]  = '{diff: 9'd256, lfsr: 9'd255, press: 1'b1};
    vecs[10] = '{diff: 9'd256, lfsr: 9'd256, press: 1'b0};

    reset = 1'b1; game_on = 1'b0; lfsr_q = '0; difficulty = '0;
    #3;
    check("reset press_out", press_out, 1'b0, 0);
    check("reset busy", busy, 1'b0, 0);
    @(negedge clk);
    reset = 1'b0;

    // difficulty 0 never presses across the whole lfsr range
    game_on = 1'b1;
    for (int i = 0; i < 600; i++) begin
      lfsr_q = 9'(i % 512);
      @(posedge clk);
      @(negedge clk);
      check("diff0 press_out", press_out, 1'b0, i);
      check("diff0 busy", busy, 1'b0, i);
    end

    foreach (vecs[v]) begin
      idle_round();
      difficulty = vecs[v].diff;
      lfsr_q     = vecs[v].lfsr;
      game_on    = 1'b1;
      pq.delete();
      if (vecs[v].press) pq.push_back(4);
      run_seq($sformatf("vec%0d", v), 1, 6, pq);
    end

    // two presses separated by the cooldown
    idle_round();
    difficulty = 9'd511; lfsr_q = 9'd5; game_on = 1'b1;
    pq.delete(); pq.push_back(4); pq.push_back(16);
    run_seq("cooldown", 1, 20, pq);

    // strict compare at the threshold, then a press on a later tick
    idle_round();
    difficulty = 9'd100; lfsr_q = 9'd100; game_on = 1'b1;
    pq.delete();
    run_seq("thresh_eq", 1, 4, pq);
    lfsr_q = 9'd99;
    pq.push_back(8);
    run_seq("thresh_below", 5, 10, pq);

    // game_on drops in the deciding tick cycle
    idle_round();
    difficulty = 9'd511; lfsr_q = 9'd0; game_on = 1'b1;
    pq.delete();
    run_seq("drop_pre", 1, 2, pq);
    @(posedge clk);
    @(negedge clk);
    game_on = 1'b0;
    run_seq("drop", 4, 8, pq);
    game_on = 1'b1;
    pq.push_back(4);
    run_seq("drop_restart", 1, 6, pq);

    // asynchronous reset during PRESS
    idle_round();
    difficulty = 9'd511; lfsr_q = 9'd0; game_on = 1'b1;
    pq.delete(); pq.push_back(4);
    run_seq("rst_pre", 1, 4, pq);
    #2 reset = 1'b1;
    #1;
    check("async_rst press_out", press_out, 1'b0, 4);
    check("async_rst busy", busy, 1'b0, 4);
    game_on = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    pq.delete();
    run_seq("rst_post", 1, 4, pq);

    // streak limiter: fourth eligible tick is skipped only with the macro
    idle_round();
    difficulty = 9'd511; lfsr_q = 9'd0; game_on = 1'b1;
    pq.delete();
`ifdef CPU_STREAK_LIMIT_EN
    pq.push_back(4); pq.push_back(16); pq.push_back(28); pq.push_back(44); pq.push_back(56);
`else
    pq.push_back(4); pq.push_back(16); pq.push_back(28); pq.push_back(40); pq.push_back(52);
`endif
    run_seq("streak", 1, 60, pq);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/computer_player.md
COMPUTER_PLAYER -- requirements
Module: computer_player

Interface
REQ-001 Parameter TICK_DIV, default 1024: clk cycles per decision tick; legal range 2..65535.
REQ-002 Parameter COOLDOWN, default 4: decision ticks skipped after each press; legal range 1..255.
REQ-003 Parameter LFSR_W, default 9: width of random input and difficulty.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 lfsr_q  input  LFSR_W  pseudo-random value from the upstream LFSR, new value every clk.
REQ-007 difficulty  input  LFSR_W  press threshold from switches; larger value means more frequent presses.
REQ-008 game_on  input  1  high while a round is in progress; low freezes the player.
REQ-009 press_out  output  1  registered single-cycle computer button press, consumed by the tug-of-war playfield.
REQ-010 busy  output  1  registered; high while in PRESS or COOLDOWN.

Function
REQ-011 Prescaler counts 0..TICK_DIV-1 and wraps to 0; tick is asserted in the cycle where the count equals TICK_DIV-1.
REQ-012 Prescaler counts only while game_on=1; when game_on=0 the prescaler holds at 0.
REQ-013 The FSM has three states: IDLE, PRESS and COOLDOWN; the reset state is IDLE.
REQ-014 IDLE->PRESS on a tick with game_on=1 and lfsr_q < difficulty (unsigned, full LFSR_W compare, sampled in the tick cycle); otherwise the FSM stays in IDLE.
REQ-015 PRESS lasts exactly one clk; press_out=1 only in that cycle, i.e. the clk after the deciding tick (latency 1).
REQ-016 PRESS->COOLDOWN unconditionally; the cooldown tick counter loads COOLDOWN on entry.
REQ-017 COOLDOWN decrements the counter on each tick; when a tick arrives with counter=1, the FSM goes to IDLE; no compare is made on that tick.
REQ-018 The first possible next press follows the (COOLDOWN+1)-th tick after the press.
REQ-019 difficulty=0 -> press_out never asserts.
REQ-020 difficulty=all-ones -> press on every eligible tick unless lfsr_q is all-ones.
REQ-021 game_on falling in any state -> FSM goes to IDLE at the next edge, press_out=0 and the cooldown counter clears.
REQ-022 If game_on falls in the same cycle as a deciding tick, no press is issued.
REQ-023 press_out never asserts on two consecutive cycles.

Reset
REQ-024 reset=1 forces asynchronously: state=IDLE, prescaler=0, cooldown counter=0, streak counter=0, press_out=0, busy=0.
REQ-025 Reset mid-PRESS aborts the pulse immediately, with no glitch after release.
REQ-026 The first tick after reset release occurs TICK_DIV cycles after the first edge that has game_on=1.

Configuration
REQ-027 Macro CPU_STREAK_LIMIT_EN: when defined, a 2-bit streak counter increments on each press and clears on any eligible IDLE tick that does not press.
REQ-028 With CPU_STREAK_LIMIT_EN defined, when the streak reaches 3, the next eligible tick is forced to no-press and the streak clears.
REQ-029 Without CPU_STREAK_LIMIT_EN, the streak logic is absent and the press decision is exactly REQ-014.

Verification (TICK_DIV=4, COOLDOWN=2)
REQ-030 reset=1 then game_on=1, difficulty=0, lfsr_q swept over 0..511 for 600 clk -> press_out=0 throughout and busy=0.
REQ-031 difficulty=511, lfsr_q=5 constant, game_on rising at cycle 0 -> press_out high at cycles 4 and 16, single-cycle each, busy high from cycle 4 through the end of the 2nd cooldown tick.
REQ-032 difficulty=100: lfsr_q=100 on a tick -> no press; lfsr_q=99 on a later tick -> press_out=1 exactly one cycle later.
REQ-033 game_on dropped in the cycle of a deciding tick (lfsr_q=0, difficulty=511) -> no press_out, state IDLE, prescaler 0.
REQ-034 reset asserted asynchronously mid-cycle during PRESS -> press_out falls without waiting for clk, and busy=0.
REQ-035 With CPU_STREAK_LIMIT_EN, lfsr_q=0 and difficulty=511 -> presses on 3 eligible ticks, 4th eligible tick skipped, pattern repeats; without the macro, no tick is skipped.
